// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave on a valid/ready bus with WAIT_CYCLES wait states and saturating access counters.
// Define BUS_MEM_ERR_EN to add the err output and reject addresses beyond DEPTH words.
module bus_mem_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`ifdef BUS_MEM_ERR_EN
  ,
  output logic        err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic [15:0]   wrCount_q, wrCount_d;
  logic [15:0]   rdCount_q, rdCount_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] index;
  logic          addrErr;
  logic          doAccess;
  logic          unusedAddr;

  assign index      = addr[AW+1:2];
  assign unusedAddr = ^{addr[31:AW+2], addr[1:0]};

`ifdef BUS_MEM_ERR_EN
  assign addrErr = |addr[31:AW+2];
  assign err     = (state_q == ACK) && addrErr;
`else
  assign addrErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      wrCount_q <= '0;
      rdCount_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      wrCount_q <= wrCount_d;
      rdCount_q <= rdCount_d;
    end
  end

  // Dropping valid while waiting abandons the request with no side effects.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d   = WAIT;
            waitCnt_d = WaitLoad;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end else if (waitCnt_q == '0) begin
          state_d = ACK;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    rdata    = '0;
    doAccess = 1'b0;
    if (state_q == ACK) begin
      ready    = 1'b1;
      doAccess = !addrErr;
      if (!write) begin
        rdata = addrErr ? 32'hDEAD_BEEF : mem_q[index];
      end
    end
  end

  always_comb begin
    wrCount_d = wrCount_q;
    rdCount_d = rdCount_q;
    if (doAccess) begin
      if (write && (wrCount_q != 16'hFFFF)) begin
        wrCount_d = wrCount_q + 16'd1;
      end
      if (!write && (rdCount_q != 16'hFFFF)) begin
        rdCount_d = rdCount_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doAccess && write) begin
      mem_q[index] <= wdata;
    end
  end

  assign wr_count = wrCount_q;
  assign rd_count = rdCount_q;

endmodule

// File: doc/bus_mem_slave.md
BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit memory words (power of 2, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before ready (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid  input  1  master request present.
REQ-006 SHALL have port write  input  1  1=write, 0=read; qualified by valid.
REQ-007 SHALL have port addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port ready  output  1  one-cycle acceptance/completion strobe.
REQ-010 SHALL have port rdata  output  32  read data, meaningful only when valid&&ready&&!write.
REQ-011 SHALL have port wr_count  output  16  completed write count.
REQ-012 SHALL have port rd_count  output  16  completed read count.

Function
REQ-013 SHALL index memory with addr[log2(DEPTH)+1:2].
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-015 SHALL go IDLE->WAIT when valid sampled high and WAIT_CYCLES>0, loading wait counter with WAIT_CYCLES-1; IDLE->ACK when valid high and WAIT_CYCLES==0.
REQ-016 SHALL, in WAIT, decrement counter each cycle and go to ACK on the cycle counter==0 is sampled.
REQ-017 SHALL, in WAIT, return to IDLE with no memory or counter update if valid is sampled low (aborted request).
REQ-018 SHALL, in ACK, drive ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL produce ready WAIT_CYCLES+1 cycles after the edge where valid is first sampled high in IDLE.
REQ-020 SHALL, in ACK with write=1, write wdata to the indexed word on that edge; with write=0, drive rdata combinationally from the indexed word during ACK.
REQ-021 SHALL drive rdata=0 whenever not in ACK with write=0.
REQ-022 SHALL, in ACK, use addr/write/wdata as presented in that cycle (master holds them stable from valid rise to ready).
REQ-023 SHALL allow back-to-back requests: valid held high after ACK re-enters WAIT/ACK from IDLE, so minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
REQ-024 SHALL increment wr_count/rd_count on each ACK of the matching type, saturating at 16'hFFFF.
REQ-025 SHALL, without BUS_MEM_ERR_EN, alias out-of-range addresses (upper bits ignored).

Reset
REQ-026 SHALL, on rst high, immediately force state=IDLE, ready=0, rdata=0, wait counter=0, wr_count=0, rd_count=0, all memory words=0.
REQ-027 SHALL, if rst is asserted mid-transaction, drop the transaction with no write performed; first request after rst deasserts starts from IDLE.

Configuration
REQ-028 SHALL, when macro BUS_MEM_ERR_EN is defined, add output err (1 bit, reset 0) asserted only during ACK when any addr[31:log2(DEPTH)+2] bit is 1.
REQ-029 SHALL, with BUS_MEM_ERR_EN and err=1, suppress memory write, drive rdata=32'hDEAD_BEEF on reads, and not increment wr_count/rd_count.
REQ-030 SHALL, without BUS_MEM_ERR_EN, have no err port and behave per REQ-025.

Verification
REQ-031 SHALL check: write addr=0x10 wdata=0xA5A5_0001, then read addr=0x10 -> ready 3 cycles after each valid, rdata=0xA5A5_0001, wr_count=1, rd_count=1.
REQ-032 SHALL check: WAIT_CYCLES=0, valid held high for 4 reads -> ready every 2nd cycle, rd_count=4.
REQ-033 SHALL check: valid dropped one cycle into WAIT on write to 0x20 -> no ready, later read of 0x20 returns 0, wr_count=0.
REQ-034 SHALL check: rst pulsed in WAIT of write to 0x04 -> ready=0 immediately, read of 0x04 after reset returns 0, counts 0.
REQ-035 SHALL check: with BUS_MEM_ERR_EN, write to 0x1000 (DEPTH=64) -> err=1 with ready, read 0x1000 returns 0xDEAD_BEEF, read 0x0 returns 0, counts unchanged; without macro, same write aliases to word 0.
REQ-036 SHALL check: 65537 writes -> wr_count saturates at 0xFFFF.
